// File: rtl/fdt_search.sv
// fdt_search: first-level directory of the allocator.
// It keeps one "full" bit per size class for every and_tree row.
// It accepts one allocation request at a time and issues a search to the
// lowest row that still has a free slot for that size.
// If no row is free, it reports a fail for the request instead.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | ready for a request; capture id/size/origin when valid
// S_SEARCH   | first-free-row search over the table (with update bypass)
// S_ISSUE    | one-cycle search pulse to the and_tree; arm the wait timer
// S_WAIT_UPD | wait for the and_tree update of the issued row, or timeout
// S_FAIL     | one-cycle fail pulse carrying the captured id

module fdt_search #(
    parameter int FDT_DEPTH   = 64,
    parameter int IDX_W       = 6,
    parameter int ID_W        = 8,
    parameter int SIZE_W      = 2,
    parameter int WAIT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              alloc_valid_in,
    output logic              alloc_ready_out,
    input  logic [ID_W-1:0]   alloc_id_in,
    input  logic [SIZE_W-1:0] alloc_size_in,
    input  logic [SIZE_W-1:0] alloc_origin_size_in,

    output logic              alloc_valid_fdt_out,
    output logic [ID_W-1:0]   alloc_id_fdt_out,
    output logic [IDX_W-1:0]  alloc_pos_fdt_out,
    output logic [SIZE_W-1:0] alloc_size_fdt_out,
    output logic [SIZE_W-1:0] alloc_origin_size_fdt_out,

    output logic              alloc_fail_valid,
    output logic [ID_W-1:0]   alloc_fail_id,

    input  logic              fdt_update_valid,
    input  logic [IDX_W-1:0]  fdt_update_idx,
    input  logic [3:0]        fdt_update_bit_sequence
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_ISSUE,
        S_WAIT_UPD,
        S_FAIL
    } state_t;

    // The wait timer exits the moment it would count down to zero, so the
    // ready comes back exactly WAIT_CYCLES cycles after the ISSUE cycle.
    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES - 1);

    state_t            state;
    state_t            state_next;

    logic [3:0]        full_tbl [FDT_DEPTH];

    logic [ID_W-1:0]   req_id;
    logic [SIZE_W-1:0] req_size;
    logic [SIZE_W-1:0] req_origin;
    logic [IDX_W-1:0]  issued_pos;
    logic [7:0]        wait_cnt;

    logic              free_found;
    logic [IDX_W-1:0]  free_pos;
    logic              row_full;
    logic              upd_match;

    assign upd_match = fdt_update_valid && (fdt_update_idx == issued_pos);

    // Full-bit table: and_tree updates land in every state; reset frees all rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < FDT_DEPTH; r++) begin
                full_tbl[r] <= '0;
            end
        end else if (fdt_update_valid) begin
            full_tbl[fdt_update_idx] <= fdt_update_bit_sequence;
        end
    end

    // Lowest row whose bit for the captured size is clear; an update arriving
    // this cycle replaces its row's bit so the search never sees stale data.
    always_comb begin
        free_found = 1'b0;
        free_pos   = '0;
        row_full   = 1'b0;
        for (int r = FDT_DEPTH - 1; r >= 0; r--) begin
            row_full = full_tbl[r][req_size];
            if (fdt_update_valid && (fdt_update_idx == IDX_W'(r))) begin
                row_full = fdt_update_bit_sequence[req_size];
            end
            if (!row_full) begin
                free_found = 1'b1;
                free_pos   = IDX_W'(r);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (alloc_valid_in) begin
                    state_next = S_SEARCH;
                end
            end
            S_SEARCH: begin
                state_next = free_found ? S_ISSUE : S_FAIL;
            end
            S_ISSUE: begin
                if (upd_match || (WAIT_LOAD == 8'd0)) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_WAIT_UPD;
                end
            end
            S_WAIT_UPD: begin
                if (upd_match || (wait_cnt <= 8'd1)) begin
                    state_next = S_IDLE;
                end
            end
            S_FAIL: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request capture on accept and the row chosen by the search.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_id     <= '0;
            req_size   <= '0;
            req_origin <= '0;
            issued_pos <= '0;
        end else begin
            if ((state == S_IDLE) && alloc_valid_in) begin
                req_id     <= alloc_id_in;
                req_size   <= alloc_size_in;
                req_origin <= alloc_origin_size_in;
            end
            if ((state == S_SEARCH) && free_found) begin
                issued_pos <= free_pos;
            end
        end
    end

    // Post-issue wait timer: loaded in ISSUE, counts down in WAIT_UPD.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == S_WAIT_UPD) && (wait_cnt != 8'd0)) begin
            wait_cnt <= wait_cnt - 8'd1;
        end
    end

    // Outputs: pulses and their fields are zero outside their own state.
    always_comb begin
        alloc_ready_out           = (state == S_IDLE) && !rst;
        alloc_valid_fdt_out       = 1'b0;
        alloc_id_fdt_out          = '0;
        alloc_pos_fdt_out         = '0;
        alloc_size_fdt_out        = '0;
        alloc_origin_size_fdt_out = '0;
        alloc_fail_valid          = 1'b0;
        alloc_fail_id             = '0;
        case (state)
            S_ISSUE: begin
                alloc_valid_fdt_out       = 1'b1;
                alloc_id_fdt_out          = req_id;
                alloc_pos_fdt_out         = issued_pos;
                alloc_size_fdt_out        = req_size;
                alloc_origin_size_fdt_out = req_origin;
            end
            S_FAIL: begin
                alloc_fail_valid = 1'b1;
                alloc_fail_id    = req_id;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fdt_search.sv
// tb_fdt_search: table vectors, directed corner sequences and a random run
// of fdt_search against a queue-based model of the full-bit table.

module tb_fdt_search;

    localparam int DEPTH = 64;
    localparam int WAITC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alloc_valid_in = 1'b0;
    logic       alloc_ready_out;
    logic [7:0] alloc_id_in = '0;
    logic [1:0] alloc_size_in = '0;
    logic [1:0] alloc_origin_size_in = '0;
    logic       alloc_valid_fdt_out;
    logic [7:0] alloc_id_fdt_out;
    logic [5:0] alloc_pos_fdt_out;
    logic [1:0] alloc_size_fdt_out;
    logic [1:0] alloc_origin_size_fdt_out;
    logic       alloc_fail_valid;
    logic [7:0] alloc_fail_id;
    logic       fdt_update_valid = 1'b0;
    logic [5:0] fdt_update_idx = '0;
    logic [3:0] fdt_update_bit_sequence = '0;

    fdt_search #(
        .FDT_DEPTH(DEPTH), .IDX_W(6), .ID_W(8), .SIZE_W(2), .WAIT_CYCLES(WAITC)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .alloc_valid_in            (alloc_valid_in),
        .alloc_ready_out           (alloc_ready_out),
        .alloc_id_in               (alloc_id_in),
        .alloc_size_in             (alloc_size_in),
        .alloc_origin_size_in      (alloc_origin_size_in),
        .alloc_valid_fdt_out       (alloc_valid_fdt_out),
        .alloc_id_fdt_out          (alloc_id_fdt_out),
        .alloc_pos_fdt_out         (alloc_pos_fdt_out),
        .alloc_size_fdt_out        (alloc_size_fdt_out),
        .alloc_origin_size_fdt_out (alloc_origin_size_fdt_out),
        .alloc_fail_valid          (alloc_fail_valid),
        .alloc_fail_id             (alloc_fail_id),
        .fdt_update_valid          (fdt_update_valid),
        .fdt_update_idx            (fdt_update_idx),
        .fdt_update_bit_sequence   (fdt_update_bit_sequence)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference table: one 4-bit full vector per row.
    logic [3:0] mtbl [$];

    function automatic void model_clear();
        mtbl.delete();
        for (int i = 0; i < DEPTH; i++) mtbl.push_back(4'b0000);
    endfunction

    // Lowest row with a free slot of the given size, or -1 when none.
    function automatic int model_first_free(input logic [1:0] sz);
        int hits[$];
        hits = mtbl.find_first_index(e) with (e[sz] == 1'b0);
        return (hits.size() == 0) ? -1 : hits[0];
    endfunction

    function automatic logic [3:0] rand_bits();
        logic [3:0] b;
        for (int j = 0; j < 4; j++) b[j] = ($urandom_range(0, 3) != 0);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_upd(input logic [5:0] idx, input logic [3:0] bits);
        fdt_update_valid = 1'b1;
        fdt_update_idx = idx;
        fdt_update_bit_sequence = bits;
        mtbl[idx] = bits;
        step();
        fdt_update_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_valid_in = 1'b0;
        fdt_update_valid = 1'b0;
        step();
        @(negedge clk);
        check("reset_outputs",
              {alloc_ready_out, alloc_valid_fdt_out, alloc_fail_valid, alloc_pos_fdt_out,
               alloc_id_fdt_out, alloc_size_fdt_out, alloc_origin_size_fdt_out, alloc_fail_id}, 0);
        step();
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check("ready_after_reset", alloc_ready_out, 1);
        step();
    endtask

    // Starts just after an edge in IDLE; ends at the negedge of the
    // ISSUE/FAIL cycle. Optional update is driven in the SEARCH cycle.
    task automatic send_req(input logic [7:0] id, input logic [1:0] sz, input logic [1:0] osz,
                            input bit bp_en, input logic [5:0] bp_idx, input logic [3:0] bp_bits,
                            input bit exp_fail, input logic [5:0] exp_pos);
        alloc_valid_in = 1'b1;
        alloc_id_in = id;
        alloc_size_in = sz;
        alloc_origin_size_in = osz;
        @(negedge clk);
        check("ready_idle", alloc_ready_out, 1);
        step();
        alloc_valid_in = 1'b0;
        if (bp_en) begin
            fdt_update_valid = 1'b1;
            fdt_update_idx = bp_idx;
            fdt_update_bit_sequence = bp_bits;
        end
        @(negedge clk);
        check("search_quiet", {alloc_ready_out, alloc_valid_fdt_out, alloc_fail_valid}, 0);
        step();
        fdt_update_valid = 1'b0;
        @(negedge clk);
        check("fdt_valid", alloc_valid_fdt_out, !exp_fail);
        check("fail_valid", alloc_fail_valid, exp_fail);
        check("ready_busy", alloc_ready_out, 0);
        if (exp_fail) begin
            check("fail_id", alloc_fail_id, id);
            check("fdt_fields_zero", {alloc_pos_fdt_out, alloc_id_fdt_out,
                                      alloc_size_fdt_out, alloc_origin_size_fdt_out}, 0);
        end else begin
            check("fdt_pos", alloc_pos_fdt_out, exp_pos);
            check("fdt_id", alloc_id_fdt_out, id);
            check("fdt_size", alloc_size_fdt_out, sz);
            check("fdt_origin", alloc_origin_size_fdt_out, osz);
            check("fail_id_zero", alloc_fail_id, 0);
        end
    endtask

    // From the ISSUE negedge: d quiet cycles, optional non-matching update,
    // then the matching update; ready must return the following cycle.
    task automatic close_match(input logic [5:0] pos, input logic [3:0] bits,
                               input int d, input int other_idx);
        for (int i = 0; i < d; i++) begin
            step();
            @(negedge clk);
            check("wait_hold", alloc_ready_out, 0);
        end
        if (other_idx >= 0) begin
            fdt_update_valid = 1'b1;
            fdt_update_idx = 6'(other_idx);
            fdt_update_bit_sequence = 4'b0000;
            mtbl[other_idx] = 4'b0000;
            step();
            fdt_update_valid = 1'b0;
            @(negedge clk);
            check("other_row_hold", alloc_ready_out, 0);
        end
        fdt_update_valid = 1'b1;
        fdt_update_idx = pos;
        fdt_update_bit_sequence = bits;
        mtbl[pos] = bits;
        step();
        fdt_update_valid = 1'b0;
        @(negedge clk);
        check("ready_after_match", alloc_ready_out, 1);
        step();
    endtask

    task automatic close_timeout();
        int n;
        n = 0;
        do begin
            step();
            @(negedge clk);
            n++;
        end while (!alloc_ready_out && n < 20);
        check("timeout_len", n, WAITC);
        step();
    endtask

    task automatic close_fail();
        step();
        @(negedge clk);
        check("ready_after_fail", alloc_ready_out, 1);
        step();
    endtask

    typedef struct {
        logic [5:0] upd_idx;
        logic [3:0] upd_bits;
        logic [7:0] id;
        logic [1:0] size;
        logic       exp_fail;
        logic [5:0] exp_pos;
    } vec_t;

    vec_t vt[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table vectors, cumulative from a clean table; each closes by timeout.
        vt[0] = '{6'd0,  4'b0010, 8'd1, 2'd1, 1'b0, 6'd1};
        vt[1] = '{6'd0,  4'b0010, 8'd2, 2'd0, 1'b0, 6'd0};
        vt[2] = '{6'd1,  4'b0010, 8'd3, 2'd1, 1'b0, 6'd2};
        vt[3] = '{6'd0,  4'b1111, 8'd4, 2'd0, 1'b0, 6'd1};
        vt[4] = '{6'd1,  4'b1111, 8'd5, 2'd0, 1'b0, 6'd2};
        vt[5] = '{6'd2,  4'b0100, 8'd6, 2'd2, 1'b0, 6'd3};
        vt[6] = '{6'd5,  4'b0001, 8'd7, 2'd3, 1'b0, 6'd2};
        vt[7] = '{6'd63, 4'b1111, 8'd8, 2'd1, 1'b0, 6'd2};

        model_clear();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            idle_upd(vt[k].upd_idx, vt[k].upd_bits);
            send_req(vt[k].id, vt[k].size, ~vt[k].size, 1'b0, 6'd0, 4'd0,
                     vt[k].exp_fail, vt[k].exp_pos);
            close_timeout();
        end

        // First request after reset lands on row 0; ready waits for row 0.
        do_reset();
        send_req(8'd5, 2'd1, 2'd1, 1'b0, 6'd0, 4'd0, 1'b0, 6'd0);
        step();
        @(negedge clk);
        check("hold_no_update", alloc_ready_out, 0);
        close_match(6'd0, 4'b0010, 0, 7);
        send_req(8'd20, 2'd1, 2'd0, 1'b0, 6'd0, 4'd0, 1'b0, 6'd1);
        close_match(6'd1, 4'b0000, 1, -1);
        send_req(8'd21, 2'd0, 2'd3, 1'b0, 6'd0, 4'd0, 1'b0, 6'd0);
        close_timeout();

        // Every row full for 4K: fail pulse, then ready right after.
        for (int r = 0; r < DEPTH; r++) idle_upd(6'(r), 4'b1000);
        send_req(8'd9, 2'd3, 2'd2, 1'b0, 6'd0, 4'd0, 1'b1, 6'd0);
        close_fail();

        // Issue at row 3; a row-7 update keeps waiting, row 3 ends it.
        for (int r = 0; r < 3; r++) idle_upd(6'(r), 4'b1111);
        idle_upd(6'd3, 4'b0000);
        send_req(8'd10, 2'd3, 2'd3, 1'b0, 6'd0, 4'd0, 1'b0, 6'd3);
        close_match(6'd3, 4'b0000, 1, 7);
        send_req(8'd11, 2'd3, 2'd1, 1'b0, 6'd0, 4'd0, 1'b0, 6'd3);
        close_timeout();

        // Update to row 0 in the SEARCH cycle is seen by that search.
        do_reset();
        mtbl[0] = 4'b0001;
        send_req(8'd12, 2'd0, 2'd0, 1'b1, 6'd0, 4'b0001, 1'b0,
                 6'(model_first_free(2'd0)));
        check("bypass_pos_model", model_first_free(2'd0), 1);
        close_match(6'd1, 4'b0000, 0, -1);

        // Reset while waiting: request dropped, table cleared.
        for (int r = 0; r < 4; r++) idle_upd(6'(r), 4'b1000);
        send_req(8'd13, 2'd3, 2'd3, 1'b0, 6'd0, 4'd0, 1'b0, 6'd4);
        step();
        @(negedge clk);
        check("wait_before_reset", alloc_ready_out, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check("ready_after_midreset", alloc_ready_out, 1);
        check("outputs_after_midreset",
              {alloc_valid_fdt_out, alloc_fail_valid, alloc_pos_fdt_out, alloc_id_fdt_out,
               alloc_size_fdt_out, alloc_origin_size_fdt_out, alloc_fail_id}, 0);
        step();
        send_req(8'd14, 2'd3, 2'd0, 1'b0, 6'd0, 4'd0, 1'b0, 6'd0);
        close_timeout();

        // Random traffic against the model.
        do_reset();
        for (int it = 0; it < 150; it++) begin
            int n_upd;
            int exp_p;
            int mode;
            bit bp;
            logic [5:0] bp_idx;
            logic [3:0] bp_bits;
            logic [1:0] sz;
            logic [7:0] id;
            n_upd = $urandom_range(0, 3);
            for (int u = 0; u < n_upd; u++) begin
                logic [5:0] ui;
                ui = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                 : 6'($urandom_range(0, 15));
                idle_upd(ui, rand_bits());
            end
            sz = 2'($urandom_range(0, 3));
            id = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 3) == 0);
            bp_idx = 6'($urandom_range(0, 15));
            bp_bits = rand_bits();
            if (bp) mtbl[bp_idx] = bp_bits;
            exp_p = model_first_free(sz);
            send_req(id, sz, 2'($urandom_range(0, 3)), bp, bp_idx, bp_bits,
                     exp_p < 0, (exp_p < 0) ? 6'd0 : 6'(exp_p));
            if (exp_p < 0) begin
                close_fail();
            end else begin
                mode = $urandom_range(0, 3);
                if (mode == 0) begin
                    close_timeout();
                end else begin
                    close_match(6'(exp_p), rand_bits(), $urandom_range(0, 3),
                                (mode == 2) ? ((exp_p + 1 + $urandom_range(0, 62)) % DEPTH) : -1);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
